// File: rtl/pico_sample_fifo_port_if.sv
// ---------------------------------------------------------------------------
// pico_sample_fifo_port_if
//
// Purpose:
//   Groups the producer handshake and the PacoBlaze I/O bus signals that
//   connect the sample FIFO peripheral to its surroundings.
//
// Signals:
//   sample_data   [31:0]  producer sample
//   sample_valid          producer offers sample_data this cycle
//   sample_ready          peripheral can accept a sample (not full)
//   port_id       [7:0]   processor port address
//   read_strobe           processor INPUT strobe
//   write_strobe          processor OUTPUT strobe
//   out_port      [7:0]   processor output data
//   in_port       [7:0]   registered read data back to the processor
//   interrupt             level interrupt request
//   interrupt_ack         processor interrupt acknowledge (one cycle)
//
// Modports:
//   master - the processor/producer side that drives requests
//   slave  - the peripheral side that answers them
// ---------------------------------------------------------------------------
interface pico_sample_fifo_port_if;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [7:0]  port_id;
  logic        read_strobe;
  logic        write_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack;

  modport master (
    output sample_data,
    output sample_valid,
    output port_id,
    output read_strobe,
    output write_strobe,
    output out_port,
    output interrupt_ack,
    input  sample_ready,
    input  in_port,
    input  interrupt
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    input  port_id,
    input  read_strobe,
    input  write_strobe,
    input  out_port,
    input  interrupt_ack,
    output sample_ready,
    output in_port,
    output interrupt
  );
endinterface

// File: rtl/pico_sample_fifo_port.sv
// ---------------------------------------------------------------------------
// pico_sample_fifo_port
//
// Purpose:
//   Port-mapped PacoBlaze peripheral that buffers 32-bit samples from a
//   fabric producer in a small circular FIFO and presents the head sample
//   to the processor as four byte-wide input ports plus a status port.
//   A level interrupt is raised whenever a sample is accepted and dropped
//   again on interrupt_ack.
//
// Parameters:
//   DEPTH   FIFO depth in 32-bit entries (power of two, 2..16)
//
// Ports:
//   clk     system clock, everything on the rising edge
//   reset   synchronous active-high reset
//   bus     slave side of pico_sample_fifo_port_if (producer handshake,
//           processor I/O bus, interrupt request/acknowledge)
//
// Port map (read):
//   8'h00 head[7:0]   8'h01 head[15:8]   8'h02 head[23:16]
//   8'h04 head[31:24] (a strobed read here pops the head)
//   8'h08 status {ovf, full, empty, 1'b0, count[3:0]}
//   anything else reads 8'h00; data ports read 8'h00 while empty
//
// Port map (write):
//   8'h08 control: bit0 flushes the FIFO, bit7 clears the overflow flag
// ---------------------------------------------------------------------------
module pico_sample_fifo_port #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  pico_sample_fifo_port_if.slave bus
);

  // Pointer width indexes the storage; the count needs one extra bit so
  // that "completely full" is distinguishable from "empty".
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [7:0] PORT_BYTE0  = 8'h00;
  localparam logic [7:0] PORT_BYTE1  = 8'h01;
  localparam logic [7:0] PORT_BYTE2  = 8'h02;
  localparam logic [7:0] PORT_BYTE3  = 8'h04;
  localparam logic [7:0] PORT_STATUS = 8'h08;

  // Sample storage and FIFO bookkeeping
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irqPend_q, irqPend_d;
  logic [7:0]    inPort_q, inPort_d;

  // Decoded events for this cycle
  logic          full;
  logic          empty;
  logic          ctrlWrite;
  logic          flush;
  logic          ovfClear;
  logic          pushAcc;
  logic          pushDrop;
  logic          popAcc;
  logic [31:0]   headWord;
  logic [3:0]    countNibble;
  logic [7:0]    statusByte;
  logic          unusedCtrlBits;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Only bits 0 and 7 of the control byte mean anything.
  assign unusedCtrlBits = ^bus.out_port[6:1];

  // Control register decode. A flush overrides everything else in the same
  // cycle: a sample offered alongside it is thrown away silently and a pop
  // is meaningless once the pointers are being zeroed.
  assign ctrlWrite = bus.write_strobe && (bus.port_id == PORT_STATUS);
  assign flush     = ctrlWrite && bus.out_port[0];
  assign ovfClear  = ctrlWrite && bus.out_port[7];

  // A sample is taken only when there is room; an offer against a full FIFO
  // is dropped and recorded, even if a pop frees a slot on the same edge,
  // because sample_ready already told the producer "no" this cycle.
  assign pushAcc  = bus.sample_valid && !full && !flush;
  assign pushDrop = bus.sample_valid &&  full && !flush;

  // Software reads bytes 0..2 first and byte 3 last, so only the byte-3
  // read consumes the entry.
  assign popAcc = bus.read_strobe && (bus.port_id == PORT_BYTE3) && !empty && !flush;

  assign headWord = mem_q[rptr_q];

  // The status byte only has room for a 4-bit count. Smaller FIFOs are
  // zero-extended; a 16-deep FIFO wraps to 0 when full and relies on the
  // full bit instead.
  generate
    if (CW >= 4) begin : gCountWide
      assign countNibble = count_q[3:0];
    end else begin : gCountNarrow
      assign countNibble = {{(4 - CW){1'b0}}, count_q};
    end
  endgenerate

  assign statusByte = {ovf_q, full, empty, 1'b0, countNibble};

  // Next-state logic for pointers, count and the sticky flags. The pop and
  // push act on independent pointers, so when both happen the count simply
  // stays where it was.
  always_comb begin
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    irqPend_d = irqPend_q;

    if (flush) begin
      rptr_d    = '0;
      wptr_d    = '0;
      count_d   = '0;
      irqPend_d = 1'b0;
      if (ovfClear) begin
        ovf_d = 1'b0;
      end
    end else begin
      if (pushAcc) begin
        wptr_d = wptr_q + PW'(1);
      end
      if (popAcc) begin
        rptr_d = rptr_q + PW'(1);
      end
      case ({pushAcc, popAcc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // A fresh overflow outranks a same-cycle clear so the event is not
      // lost.
      if (ovfClear) begin
        ovf_d = 1'b0;
      end
      if (pushDrop) begin
        ovf_d = 1'b1;
      end

      // Likewise a new sample outranks an acknowledge landing on the same
      // edge, so the processor is always told about it.
      if (bus.interrupt_ack) begin
        irqPend_d = 1'b0;
      end
      if (pushAcc) begin
        irqPend_d = 1'b1;
      end
    end
  end

  // Read multiplexer. It is evaluated from the pre-edge head, so the byte-3
  // read that pops an entry still returns that entry's top byte.
  always_comb begin
    inPort_d = 8'h00;
    case (bus.port_id)
      PORT_BYTE0:  inPort_d = empty ? 8'h00 : headWord[7:0];
      PORT_BYTE1:  inPort_d = empty ? 8'h00 : headWord[15:8];
      PORT_BYTE2:  inPort_d = empty ? 8'h00 : headWord[23:16];
      PORT_BYTE3:  inPort_d = empty ? 8'h00 : headWord[31:24];
      PORT_STATUS: inPort_d = statusByte;
      default:     inPort_d = 8'h00;
    endcase
  end

  // Control state and the registered read data. Reset empties the FIFO by
  // zeroing the bookkeeping; the stored words are simply left stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      irqPend_q <= 1'b0;
      inPort_q  <= 8'h00;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      irqPend_q <= irqPend_d;
      inPort_q  <= inPort_d;
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (pushAcc && !reset) begin
      mem_q[wptr_q] <= bus.sample_data;
    end
  end

  assign bus.sample_ready = !full;
  assign bus.in_port      = inPort_q;
  assign bus.interrupt    = irqPend_q;

endmodule

// File: doc/pico_sample_fifo_port.md
# pico_sample_fifo_port

Port-mapped peripheral on the PacoBlaze I/O bus. It buffers 32-bit samples from a fabric producer in a small FIFO and presents the head sample to the processor as four byte-wide input ports. It raises a level interrupt when new samples arrive and clears it on `interrupt_ack`. Sits between sample sources (counters, switch samplers) and the processor's `in_port` multiplexer; the processor drains it from its interrupt service routine.

## Interface
- `DEPTH`, 8: FIFO depth in 32-bit entries; power of two, 2..16.
- `clk` in 1: single system clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `sample_data` in 32: producer sample.
- `sample_valid` in 1: producer offers `sample_data` this cycle.
- `sample_ready` out 1: combinational `!full`; a sample is accepted when valid & ready.
- `port_id` in 8: processor port address.
- `read_strobe` in 1: processor INPUT strobe.
- `write_strobe` in 1: processor OUTPUT strobe.
- `out_port` in 8: processor output data.
- `in_port` out 8: registered read data to the processor.
- `interrupt` out 1: level interrupt request.
- `interrupt_ack` in 1: processor interrupt acknowledge, one cycle.

## Operation
- Storage is a circular buffer of `DEPTH` x 32 bits with read pointer, write pointer and a count of width log2(DEPTH)+1. Pointers wrap modulo `DEPTH`. `full` means count==DEPTH; `empty` means count==0.
- Push: `sample_valid & !full` writes at wptr, then wptr+1 and count+1.
- Overflow: `sample_valid & full` drops the sample and sets sticky `ovf`. This holds even if a pop occurs in the same cycle.
- Read map. `in_port` is registered every cycle from the current `port_id`:
  - 8'h00: head[7:0]
  - 8'h01: head[15:8]
  - 8'h02: head[23:16]
  - 8'h04: head[31:24]
  - 8'h08: status = {ovf, full, empty, 1'b0, count[3:0]}; count is zero-extended when DEPTH<16, and DEPTH=16 reports full in bit6 with count[3:0]=0.
  - Any other port: 8'h00.
  - When empty, all data ports read 8'h00.
- Pop: `read_strobe & port_id==8'h04 & !empty` advances rptr and decrements count. Pop on empty is ignored. Reading ports 00/01/02/08 never pops. Software reads bytes 0,1,2 first, then 3.
- Simultaneous push and pop, not full: both occur and count is unchanged.
- Control write, `write_strobe & port_id==8'h08`:
  - `out_port[0]`=1 flushes: rptr=wptr=count=0, and `irq_pend` is cleared.
  - `out_port[7]`=1 clears `ovf`.
  - Flush wins over a same-cycle push; that sample is discarded and does not set `ovf`.
- Writes to other ports are ignored.
- Interrupt: `irq_pend` is set on any accepted push and cleared on `interrupt_ack`. If set and clear occur in the same cycle, set wins, so no event is lost. `interrupt` = `irq_pend`.
- Reset clears pointers, count, `ovf`, `irq_pend` and `in_port` (to 8'h00). Storage contents are not reset. Reset mid-transfer discards all buffered samples.

## Timing
- Push visible at head and in status: `in_port` reflects it one cycle after the push edge for an unchanged `port_id`.
- Read latency: `in_port` is valid one clock after `port_id` is presented. This fits the two-cycle INPUT instruction.
- Pop takes effect on the edge where `read_strobe` is high. The registered `in_port` for that same cycle still carries the pre-pop byte 3.
- `interrupt` rises one clock after the accepting push edge and falls one clock after the `interrupt_ack` edge, unless a push lands on that ack edge.
- `sample_ready` reflects count combinationally, so it changes the cycle after a push fills or a pop unfills the FIFO.
- Outputs after reset: `in_port`=00, `interrupt`=0, `sample_ready`=1.

## Test plan
- Reset, then read port 08 -> `in_port`=8'h20 (empty); `interrupt`=0; `sample_ready`=1.
- Push 32'hDEADBEEF, then read ports 00,01,02,04 -> 8'hEF,8'hBE,8'hAD,8'hDE. `interrupt` goes high one cycle after the push. The pop on 04 returns status to 8'h20.
- Push 9 samples 1..9 with DEPTH=8 -> `sample_ready`=0 after the 8th. The 9th is dropped; status reads 8'hC8. Eight pops return 1..8 in order, verifying wraparound after a further 4 push/pop pairs.
- Push on the same edge as `interrupt_ack` -> `interrupt` stays 1. An ack with no push -> `interrupt` goes 0 the next cycle.
- With 3 entries, write 8'h81 to port 08 while pushing -> count 0 and `ovf` 0; status reads 8'h20; `interrupt` goes 0.
- Simultaneous push and pop at count 4 -> count stays 4 and the head advances to the next entry. Read of unmapped port 8'h10 -> 8'h00.
